// File: rtl/stdp_pkg.sv
// Shared FSM state type, default parameter values and the weight clamp helper
// used throughout the STDP learning engine.
package stdp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } stdp_state_e;

  localparam int NUM_PRE_DEF  = 16;
  localparam int WINDOW_DEF   = 16;
  localparam int WEIGHT_W_DEF = 4;
  localparam int W_INIT_DEF   = 2;
  localparam int A_MAX_DEF    = 3;

  // Clamp a signed intermediate weight into [0, hi]; weights never wrap.
  function automatic int sat_weight(input int value, input int hi);
    int r;
    if (value < 32'sd0) begin
      r = 32'sd0;
    end else if (value > hi) begin
      r = hi;
    end else begin
      r = value;
    end
    return r;
  endfunction

endpackage

// File: rtl/stdp_delta_unit.sv
// Combinational per-channel weight update: finds spike ages in the prior
// history, derives the LTP/LTD magnitude and saturates the new weight.
module stdp_delta_unit
  import stdp_pkg::*;
#(
  parameter int WINDOW   = WINDOW_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int A_MAX    = A_MAX_DEF
) (
  input  logic [WINDOW-1:0]   pre_hist_i,
  input  logic [WINDOW-1:0]   post_hist_i,
  input  logic [WEIGHT_W-1:0] w_old_i,
  output logic [WEIGHT_W-1:0] w_new_o
);

  localparam int W_MAX = (32'sd1 <<< WEIGHT_W) - 32'sd1;

  int age_pre_s;
  int age_post_s;
  int ltp_s;
  int ltd_s;
  int sum_s;
  int sat_s;

  // Age 0 means "no earlier spike"; scanning downwards leaves the nearest one.
  always_comb begin
    age_pre_s  = 32'sd0;
    age_post_s = 32'sd0;
    for (int k = WINDOW - 1; k >= 1; k--) begin
      age_pre_s  = pre_hist_i[k]  ? k : age_pre_s;
      age_post_s = post_hist_i[k] ? k : age_post_s;
    end
  end

  // Potentiation when post fires alone, depression when pre fires alone.
  always_comb begin
    ltp_s = 32'sd0;
    ltd_s = 32'sd0;
    if (post_hist_i[0] && !pre_hist_i[0] && (age_pre_s != 32'sd0) && (age_pre_s <= A_MAX)) begin
      ltp_s = A_MAX + 32'sd1 - age_pre_s;
    end else begin
      ltp_s = 32'sd0;
    end
    if (pre_hist_i[0] && !post_hist_i[0] && (age_post_s != 32'sd0) && (age_post_s <= A_MAX)) begin
      ltd_s = A_MAX + 32'sd1 - age_post_s;
    end else begin
      ltd_s = 32'sd0;
    end
  end

  // Apply the change and clamp to the legal weight range.
  always_comb begin
    sum_s   = int'(w_old_i) + ltp_s - ltd_s;
    sat_s   = sat_weight(sum_s, W_MAX);
    w_new_o = sat_s[WEIGHT_W-1:0];
  end

endmodule

// File: rtl/stdp_learning_engine.sv
// Spike-timing-dependent plasticity engine: keeps per-channel spike histories
// and, after each learning step, sweeps every synapse weight once.
module stdp_learning_engine
  import stdp_pkg::*;
#(
  parameter int NUM_PRE  = NUM_PRE_DEF,
  parameter int WINDOW   = WINDOW_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int W_INIT   = W_INIT_DEF,
  parameter int A_MAX    = A_MAX_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       step_valid,
  output logic                       step_ready,
  input  logic [NUM_PRE-1:0]         pre_spike,
  input  logic                       post_spike,
  input  logic                       learn_en,
  input  logic [$clog2(NUM_PRE)-1:0] rd_addr,
  output logic [WEIGHT_W-1:0]        rd_data,
  output logic                       scan_done,
  output logic                       step_overrun
);

  localparam int                  IDX_W     = $clog2(NUM_PRE);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_PRE - 1);
  localparam logic [IDX_W:0]      NUM_PRE_V = (IDX_W + 1)'(NUM_PRE);
  localparam logic [WEIGHT_W-1:0] W_INIT_V  = WEIGHT_W'(W_INIT);

  stdp_state_e         state_q;
  logic [IDX_W-1:0]    idx_q;
  logic                step_ready_q;
  logic                scan_done_q;
  logic                overrun_q;
  logic [WINDOW-1:0]   pre_hist_q [NUM_PRE];
  logic [WINDOW-1:0]   post_hist_q;
  logic [WEIGHT_W-1:0] weight_q [NUM_PRE];
  logic [WEIGHT_W-1:0] rd_data_q;

  logic                accept_s;
  logic                start_scan_s;
  logic [WINDOW-1:0]   cur_pre_hist_s;
  logic [WEIGHT_W-1:0] cur_w_s;
  logic [WEIGHT_W-1:0] w_new_s;

  assign accept_s       = step_valid && step_ready_q;
  assign start_scan_s   = accept_s && learn_en && (post_spike || (|pre_spike));
  assign cur_pre_hist_s = pre_hist_q[idx_q];
  assign cur_w_s        = weight_q[idx_q];

  stdp_delta_unit #(
    .WINDOW   (WINDOW),
    .WEIGHT_W (WEIGHT_W),
    .A_MAX    (A_MAX)
  ) u_delta (
    .pre_hist_i  (cur_pre_hist_s),
    .post_hist_i (post_hist_q),
    .w_old_i     (cur_w_s),
    .w_new_o     (w_new_s)
  );

  // Scan sequencer with registered handshake and completion pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      step_ready_q <= 1'b1;
      scan_done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          scan_done_q <= 1'b0;
          idx_q       <= '0;
          if (start_scan_s) begin
            state_q      <= ST_SCAN;
            step_ready_q <= 1'b0;
          end else begin
            state_q      <= ST_IDLE;
            step_ready_q <= 1'b1;
          end
        end
        ST_SCAN: begin
          scan_done_q  <= 1'b0;
          step_ready_q <= 1'b0;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
            idx_q   <= '0;
          end else begin
            state_q <= ST_SCAN;
            idx_q   <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          idx_q        <= '0;
          scan_done_q  <= 1'b1;
          step_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= ST_IDLE;
          idx_q        <= '0;
          scan_done_q  <= 1'b0;
          step_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Sticky record of any step offered while busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else if (step_valid && !step_ready_q) begin
      overrun_q <= 1'b1;
    end else begin
      overrun_q <= overrun_q;
    end
  end

  // Histories shift only on accepted steps; newest spike lands in bit 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      post_hist_q <= '0;
      for (int i = 0; i < NUM_PRE; i++) begin
        pre_hist_q[i] <= '0;
      end
    end else if (accept_s) begin
      post_hist_q <= {post_hist_q[WINDOW-2:0], post_spike};
      for (int i = 0; i < NUM_PRE; i++) begin
        pre_hist_q[i] <= {pre_hist_q[i][WINDOW-2:0], pre_spike[i]};
      end
    end else begin
      post_hist_q <= post_hist_q;
    end
  end

  // Weight store: one write per scan cycle, read port returns pre-write data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
      for (int i = 0; i < NUM_PRE; i++) begin
        weight_q[i] <= W_INIT_V;
      end
    end else begin
      if ({1'b0, rd_addr} < NUM_PRE_V) begin
        rd_data_q <= weight_q[rd_addr];
      end else begin
        rd_data_q <= '0;
      end
      if (state_q == ST_SCAN) begin
        weight_q[idx_q] <= w_new_s;
      end
    end
  end

  assign step_ready   = step_ready_q;
  assign rd_data      = rd_data_q;
  assign scan_done    = scan_done_q;
  assign step_overrun = overrun_q;

endmodule

// File: tb/tb_stdp_learning_engine.sv
// Directed bench for stdp_learning_engine: weight reads are checked by a
// scoreboard monitor, step latency and flags are checked inline.
module tb_stdp_learning_engine;

  localparam int N  = 16;
  localparam int WW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          step_valid = 1'b0;
  logic          step_ready;
  logic [N-1:0]  pre_spike = '0;
  logic          post_spike = 1'b0;
  logic          learn_en = 1'b1;
  logic [3:0]    rd_addr = 4'd0;
  logic [WW-1:0] rd_data;
  logic          scan_done;
  logic          step_overrun;

  int total  = 0;
  int passed = 0;
  int exp_w [N];
  int exp_q [$];
  int addr_q [$];
  logic rd_en   = 1'b0;
  logic rd_en_d = 1'b0;

  always #5 clock = ~clock;

  stdp_learning_engine #(
    .NUM_PRE(N), .WINDOW(16), .WEIGHT_W(WW), .W_INIT(2), .A_MAX(3)
  ) dut (
    .clock(clock), .reset(reset), .step_valid(step_valid), .step_ready(step_ready),
    .pre_spike(pre_spike), .post_spike(post_spike), .learn_en(learn_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .scan_done(scan_done),
    .step_overrun(step_overrun)
  );

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  // Read monitor: rd_data is due one clock after the address was driven.
  always @(posedge clock) rd_en_d <= rd_en;
  always @(negedge clock) begin
    if (rd_en_d) begin
      int e;
      int a;
      if (exp_q.size() == 0) begin
        check("rd_scoreboard_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        check($sformatf("rd_data[%0d]", a), int'(rd_data), e);
      end
    end
  end

  task automatic read_one(input int a);
    @(negedge clock);
    rd_addr = 4'(a);
    rd_en   = 1'b1;
    exp_q.push_back(exp_w[a]);
    addr_q.push_back(a);
    @(negedge clock);
    rd_en = 1'b0;
    @(negedge clock);
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) begin
      @(negedge clock);
      rd_addr = 4'(i);
      rd_en   = 1'b1;
      exp_q.push_back(exp_w[i]);
      addr_q.push_back(i);
    end
    @(negedge clock);
    rd_en = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b0;
    step_valid = 1'b0;
    pre_spike  = '0;
    post_spike = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_step_ready", int'(step_ready), 1);
    check("rst_scan_done", int'(scan_done), 0);
    check("rst_overrun", int'(step_overrun), 0);
    reset = 1'b1;
    for (int i = 0; i < N; i++) exp_w[i] = 2;
    @(negedge clock);
  endtask

  // One step; scan_done is expected N+2 edges after issue, counting the accept edge.
  task automatic step(input logic [N-1:0] pre, input logic post, input logic learn,
                      input logic exp_scan, input string name);
    int   cnt;
    logic got;
    cnt = 0;
    got = 1'b0;
    @(negedge clock);
    step_valid = 1'b1;
    pre_spike  = pre;
    post_spike = post;
    learn_en   = learn;
    @(posedge clock);
    cnt = 1;
    @(negedge clock);
    step_valid = 1'b0;
    pre_spike  = '0;
    post_spike = 1'b0;
    while (!got && cnt < N + 6) begin
      @(posedge clock);
      cnt++;
      @(negedge clock);
      got = scan_done;
    end
    if (exp_scan) check({name, "_latency"}, got ? cnt : -1, N + 2);
    else          check({name, "_noscan"}, int'(got), 0);
  endtask

  task automatic empties(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b1, 1'b0, "empty");
  endtask

  initial begin
    int sat_tbl [5];
    sat_tbl = '{5, 8, 11, 14, 15};

    // Reset values
    do_reset();
    read_all();

    // Ch3 pre then post one step later: +3
    step(16'h0008, 1'b0, 1'b1, 1'b1, "b_pre");
    step(16'h0000, 1'b1, 1'b1, 1'b1, "b_post");
    exp_w[3] = 5;
    read_all();

    // Post then ch0 pre two steps later: age 2 gives -2; repeat clamps at 0
    do_reset();
    step(16'h0000, 1'b1, 1'b1, 1'b1, "c_post");
    empties(1);
    step(16'h0001, 1'b0, 1'b1, 1'b1, "c_pre");
    exp_w[0] = 0;
    read_all();
    empties(4);
    step(16'h0000, 1'b1, 1'b1, 1'b1, "c_post2");
    empties(1);
    step(16'h0001, 1'b0, 1'b1, 1'b1, "c_pre2");
    read_one(0);

    // Age 4 is beyond A_MAX: no change
    do_reset();
    step(16'h0020, 1'b0, 1'b1, 1'b1, "d_pre");
    empties(3);
    step(16'h0000, 1'b1, 1'b1, 1'b1, "d_post");
    read_all();

    // Step offered during SCAN is dropped and flagged
    do_reset();
    @(negedge clock);
    step_valid = 1'b1; pre_spike = 16'h0008; post_spike = 1'b0; learn_en = 1'b1;
    @(negedge clock);
    pre_spike = '0; post_spike = 1'b1;
    @(negedge clock);
    step_valid = 1'b0; post_spike = 1'b0;
    check("e_overrun_set", int'(step_overrun), 1);
    check("e_ready_busy", int'(step_ready), 0);
    for (int c = 0; c < 40 && !scan_done; c++) @(negedge clock);
    check("e_scan_done", int'(scan_done), 1);
    step(16'h0000, 1'b1, 1'b1, 1'b1, "e_post");
    exp_w[3] = 5;
    read_all();
    check("e_overrun_sticky", int'(step_overrun), 1);

    // Reset mid-scan leaves no history or weights behind
    do_reset();
    @(negedge clock);
    step_valid = 1'b1; pre_spike = 16'h0008;
    @(negedge clock);
    step_valid = 1'b0; pre_spike = '0;
    repeat (5) @(negedge clock);
    do_reset();
    step(16'h0000, 1'b1, 1'b1, 1'b1, "r_post");
    read_all();

    // History keeps shifting with learning disabled
    do_reset();
    step(16'h0080, 1'b0, 1'b0, 1'b0, "f_nolearn");
    step(16'h0000, 1'b1, 1'b1, 1'b1, "f_post");
    exp_w[7] = 5;
    read_all();

    // Repeated potentiation saturates at W_MAX
    do_reset();
    for (int r = 0; r < 5; r++) begin
      step(16'h0008, 1'b0, 1'b1, 1'b1, "s_pre");
      step(16'h0000, 1'b1, 1'b1, 1'b1, "s_post");
      exp_w[3] = sat_tbl[r];
      read_one(3);
      empties(4);
    end
    read_all();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
